// File: rtl/exe_branch_unit.sv
// rtl/exe_branch_unit.sv - EXE-stage branch/jump resolution with a held redirect
// Optional build macro: BRANCH_STATS_EN adds saturating branch statistics counters.
module exe_branch_unit #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ALIGN_BITS = 2,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk_in,
  input  logic                  rst_n_in,
  input  logic                  valid_in,
  output logic                  ready_out,
  input  logic [31:0]           inst_in,
  input  logic [ADDR_WIDTH-1:0] inst_address_in,
  input  logic [DATA_WIDTH-1:0] op1_in,
  input  logic [DATA_WIDTH-1:0] op2_in,
  input  logic                  flush_in,
  input  logic                  jump_ack_in,
  output logic                  result_valid_out,
  output logic                  jump_enable_out,
  output logic [ADDR_WIDTH-1:0] jump_address_out,
  output logic [DATA_WIDTH-1:0] link_data_out,
  output logic                  misalign_out,
  output logic                  illegal_out
`ifdef BRANCH_STATS_EN
  ,
  output logic [CNT_WIDTH-1:0]  taken_cnt_out,
  output logic [CNT_WIDTH-1:0]  not_taken_cnt_out,
  output logic [CNT_WIDTH-1:0]  mispredict_free_cnt_out
`endif
);

  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  typedef enum logic {
    IDLE    = 1'b0,
    PENDING = 1'b1
  } state_t;

  if (ALIGN_BITS < 1 || ALIGN_BITS > 2 || CNT_WIDTH < 1 || ADDR_WIDTH < 21 || DATA_WIDTH < 12)
  begin : g_param_check
    $error("exe_branch_unit: unsupported parameter combination");
  end

  state_t state_q, state_d;

  logic                  accept;
  logic [6:0]            opcode;
  logic [2:0]            funct3;
  logic                  is_jal, is_jalr, is_branch;
  logic                  branch_illegal, cond_true, decoded;
  logic                  taken, misaligned, redirect;
  logic [ADDR_WIDTH-1:0] imm_j, imm_b, target, pc_plus4, jalr_target;
  logic [DATA_WIDTH-1:0] imm_i, jalr_sum;

  assign ready_out = (state_q == IDLE);
  assign accept    = valid_in & ready_out & ~flush_in;

  always_comb begin
    opcode    = inst_in[6:0];
    funct3    = inst_in[14:12];
    is_jal    = (opcode == OPC_JAL);
    is_jalr   = (opcode == OPC_JALR);
    is_branch = (opcode == OPC_BRANCH);

    imm_j = {{(ADDR_WIDTH-20){inst_in[31]}}, inst_in[19:12], inst_in[20], inst_in[30:21], 1'b0};
    imm_b = {{(ADDR_WIDTH-12){inst_in[31]}}, inst_in[7], inst_in[30:25], inst_in[11:8], 1'b0};
    imm_i = {{(DATA_WIDTH-11){inst_in[31]}}, inst_in[30:20]};

    pc_plus4    = inst_address_in + ADDR_WIDTH'(4);
    jalr_sum    = op1_in + imm_i;
    jalr_target = ADDR_WIDTH'(jalr_sum);
    jalr_target[0] = 1'b0;

    case (funct3)
      3'b000:  cond_true = (op1_in == op2_in);
      3'b001:  cond_true = (op1_in != op2_in);
      3'b100:  cond_true = ($signed(op1_in) <  $signed(op2_in));
      3'b101:  cond_true = ($signed(op1_in) >= $signed(op2_in));
      3'b110:  cond_true = (op1_in <  op2_in);
      3'b111:  cond_true = (op1_in >= op2_in);
      default: cond_true = 1'b0;
    endcase

    branch_illegal = is_branch && (funct3 == 3'b010 || funct3 == 3'b011);
    decoded        = is_jal | is_jalr | (is_branch & ~branch_illegal);

    if (is_jal)       target = inst_address_in + imm_j;
    else if (is_jalr) target = jalr_target;
    else              target = inst_address_in + imm_b;

    taken      = is_jal | is_jalr | (is_branch & ~branch_illegal & cond_true);
    misaligned = taken && (|target[ALIGN_BITS-1:0]);
    redirect   = taken & ~misaligned;
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) state_q <= IDLE;
    else           state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept && redirect) state_d = PENDING;
      PENDING: if (jump_ack_in)        state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (flush_in) state_d = IDLE;
  end

  // Results are single-cycle pulses except a redirect, which is held until acked or flushed.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      result_valid_out <= 1'b0;
      jump_enable_out  <= 1'b0;
      jump_address_out <= '0;
      link_data_out    <= '0;
      misalign_out     <= 1'b0;
      illegal_out      <= 1'b0;
    end else if (flush_in || (state_q == PENDING && jump_ack_in) || (state_q == IDLE && !accept)) begin
      result_valid_out <= 1'b0;
      jump_enable_out  <= 1'b0;
      jump_address_out <= '0;
      link_data_out    <= '0;
      misalign_out     <= 1'b0;
      illegal_out      <= 1'b0;
    end else if (state_q == IDLE) begin
      result_valid_out <= is_jal | is_jalr | is_branch;
      jump_enable_out  <= redirect;
      jump_address_out <= decoded ? target : '0;
      link_data_out    <= (is_jal | is_jalr) ? DATA_WIDTH'(pc_plus4) : '0;
      misalign_out     <= misaligned;
      illegal_out      <= branch_illegal;
    end
  end

`ifdef BRANCH_STATS_EN
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      taken_cnt_out           <= '0;
      not_taken_cnt_out       <= '0;
      mispredict_free_cnt_out <= '0;
    end else if (accept) begin
      if (is_branch && !branch_illegal) begin
        if (taken) begin
          if (taken_cnt_out != '1) taken_cnt_out <= taken_cnt_out + 1'b1;
        end else begin
          if (not_taken_cnt_out != '1) not_taken_cnt_out <= not_taken_cnt_out + 1'b1;
        end
      end
      if ((is_jal || is_jalr) && mispredict_free_cnt_out != '1)
        mispredict_free_cnt_out <= mispredict_free_cnt_out + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_exe_branch_unit.sv
// tb/tb_exe_branch_unit.sv - directed bench for exe_branch_unit with a behavioural result model
module tb_exe_branch_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid = 1'b0;
  logic        ready;
  logic [31:0] inst = 32'd0;
  logic [31:0] pc = 32'd0;
  logic [31:0] op1 = 32'd0;
  logic [31:0] op2 = 32'd0;
  logic        flush = 1'b0;
  logic        ack = 1'b0;
  logic        res_valid, jen, mis, ill;
  logic [31:0] jaddr, link;
`ifdef BRANCH_STATS_EN
  logic [15:0] taken_cnt, not_taken_cnt, mf_cnt;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  exe_branch_unit dut (
    .clk_in(clk), .rst_n_in(rst_n), .valid_in(valid), .ready_out(ready),
    .inst_in(inst), .inst_address_in(pc), .op1_in(op1), .op2_in(op2),
    .flush_in(flush), .jump_ack_in(ack),
    .result_valid_out(res_valid), .jump_enable_out(jen), .jump_address_out(jaddr),
    .link_data_out(link), .misalign_out(mis), .illegal_out(ill)
`ifdef BRANCH_STATS_EN
    , .taken_cnt_out(taken_cnt), .not_taken_cnt_out(not_taken_cnt),
    .mispredict_free_cnt_out(mf_cnt)
`endif
  );

  typedef struct packed {
    logic        valid;
    logic        jen;
    logic [31:0] addr;
    logic [31:0] link;
    logic        mis;
    logic        ill;
  } res_t;

  // Architectural meaning of one instruction, from RISC-V rules.
  function automatic res_t predict(input logic [31:0] i, input logic [31:0] p,
                                   input logic [31:0] a, input logic [31:0] b);
    res_t   r;
    int     imm;
    longint sa, sb;
    logic [31:0] tgt;
    bit     tk, is_jump;
    r = '0; tk = 0; is_jump = 0; tgt = 32'd0;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (i[6:0])
      7'b1101111: begin
        imm = int'($signed({i[31], i[19:12], i[20], i[30:21], 1'b0}));
        tgt = p + imm; tk = 1; is_jump = 1;
      end
      7'b1100111: begin
        imm = int'($signed(i[31:20]));
        tgt = (a + imm) & 32'hFFFF_FFFE; tk = 1; is_jump = 1;
      end
      7'b1100011: begin
        imm = int'($signed({i[31], i[7], i[30:25], i[11:8], 1'b0}));
        tgt = p + imm;
        case (i[14:12])
          3'd0: tk = (a == b);
          3'd1: tk = (a != b);
          3'd4: tk = (sa < sb);
          3'd5: tk = (sa >= sb);
          3'd6: tk = ({32'd0, a} < {32'd0, b});
          3'd7: tk = ({32'd0, a} >= {32'd0, b});
          default: begin
            r.valid = 1'b1; r.ill = 1'b1;
            return r;
          end
        endcase
      end
      default: return r;
    endcase
    r.valid = 1'b1;
    r.addr  = tgt;
    r.link  = is_jump ? p + 32'd4 : 32'd0;
    r.mis   = tk && (tgt % 4 != 0);
    r.jen   = tk && !r.mis;
    return r;
  endfunction

  res_t m_res, m_next;
  logic m_pend;
  assign m_next = predict(inst, pc, op1, op2);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_res <= '0; m_pend <= 1'b0;
    end else if (flush) begin
      m_res <= '0; m_pend <= 1'b0;
    end else if (m_pend) begin
      if (ack) begin m_res <= '0; m_pend <= 1'b0; end
    end else if (valid) begin
      m_res <= m_next; m_pend <= m_next.jen;
    end else begin
      m_res <= '0;
    end
  end

  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  always @(negedge clk)
    chk("cycle_outputs", {3'd0, ready, res_valid, jen, jaddr, link, mis, ill},
        {3'd0, ~m_pend, m_res.valid, m_res.jen, m_res.addr, m_res.link, m_res.mis, m_res.ill});

  function automatic logic [31:0] enc_b(input logic [2:0] f3, input logic [12:0] imm);
    return {imm[12], imm[10:5], 5'd0, 5'd0, f3, imm[4:1], imm[11], 7'b1100011};
  endfunction
  function automatic logic [31:0] enc_jal(input logic [20:0] imm);
    return {imm[20], imm[10:1], imm[11], imm[19:12], 5'd0, 7'b1101111};
  endfunction
  function automatic logic [31:0] enc_jalr(input logic [11:0] imm);
    return {imm, 5'd0, 3'b000, 5'd0, 7'b1100111};
  endfunction

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic issue(input logic [31:0] i, input logic [31:0] p,
                       input logic [31:0] a, input logic [31:0] b);
    @(posedge clk); #1;
    valid = 1'b1; inst = i; pc = p; op1 = a; op2 = b;
    @(posedge clk); #1;
    valid = 1'b0;
  endtask

  task automatic ack_now();
    ack = 1'b1; step(1); ack = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    step(2);
    chk("reset_ready", ready, 1);
    chk("reset_valid", res_valid, 0);
    chk("reset_addr", jaddr, 0);
    rst_n = 1'b1;
    step(1);

    issue(enc_b(3'd0, 13'd16), 32'h100, 32'd5, 32'd5);
    chk("beq_valid", res_valid, 1);
    chk("beq_jen", jen, 1);
    chk("beq_addr", jaddr, 32'h110);
    chk("beq_ready", ready, 0);
    step(2);
    chk("beq_hold_addr", jaddr, 32'h110);
    chk("beq_hold_ready", ready, 0);
    ack_now();
    chk("beq_ack_valid", res_valid, 0);
    chk("beq_ack_ready", ready, 1);

    issue(enc_b(3'd1, 13'd16), 32'h100, 32'd7, 32'd7);
    chk("bne_valid", res_valid, 1);
    chk("bne_jen", jen, 0);
    chk("bne_ready", ready, 1);
    chk("bne_addr", jaddr, 32'h110);
    step(1);
    chk("bne_pulse_end", res_valid, 0);

    issue(enc_b(3'd4, 13'd8), 32'h200, 32'hFFFF_FFFF, 32'd1);
    chk("blt_jen", jen, 1);
    chk("blt_addr", jaddr, 32'h208);
    ack_now();
    chk("blt_same_cycle_ack", ready, 1);
    issue(enc_b(3'd6, 13'd8), 32'h200, 32'hFFFF_FFFF, 32'd1);
    chk("bltu_valid", res_valid, 1);
    chk("bltu_jen", jen, 0);
    issue(enc_b(3'd5, 13'h1FF0), 32'h200, 32'hFFFF_FFFF, 32'd1);
    chk("bge_jen", jen, 0);
    chk("bge_addr", jaddr, 32'h1F0);
    issue(enc_b(3'd7, 13'h1FF0), 32'h200, 32'hFFFF_FFFF, 32'd1);
    chk("bgeu_jen", jen, 1);
    ack_now();

    issue(enc_jalr(12'd0), 32'h300, 32'h203, 32'd0);
    chk("jalr_addr", jaddr, 32'h202);
    chk("jalr_link", link, 32'h304);
    chk("jalr_mis", mis, 1);
    chk("jalr_jen", jen, 0);
    chk("jalr_ready", ready, 1);
    issue(enc_jalr(12'hFFF), 32'h300, 32'h205, 32'd0);
    chk("jalr2_addr", jaddr, 32'h204);
    chk("jalr2_jen", jen, 1);
    ack_now();

    issue(enc_b(3'd2, 13'd8), 32'h100, 32'd1, 32'd1);
    chk("illegal_flag", ill, 1);
    chk("illegal_jen", jen, 0);
    issue(32'h0000_0013, 32'h100, 32'd1, 32'd1);
    chk("unknown_valid", res_valid, 0);
    chk("unknown_ready", ready, 1);

    ack = 1'b1; step(2); ack = 1'b0;
    issue(enc_b(3'd0, 13'd4), 32'h100, 32'd0, 32'd0);
    step(1);
    chk("idle_ack_ignored", ready, 0);
    ack_now();

    issue(enc_jal(21'h1FFFF8), 32'h400, 32'd0, 32'd0);
    chk("jal_addr", jaddr, 32'h3F8);
    chk("jal_link", link, 32'h404);
    step(3);
    chk("jal_hold_addr", jaddr, 32'h3F8);
    chk("jal_hold_ready", ready, 0);
    flush = 1'b1; ack = 1'b1;
    step(1);
    flush = 1'b0; ack = 1'b0;
    chk("flush_valid", res_valid, 0);
    chk("flush_addr", jaddr, 0);
    chk("flush_ready", ready, 1);

    valid = 1'b1; inst = enc_b(3'd0, 13'd16); pc = 32'h100; op1 = 32'd3; op2 = 32'd3; flush = 1'b1;
    step(1);
    valid = 1'b0; flush = 1'b0;
    chk("flush_drop_valid", res_valid, 0);
    chk("flush_drop_ready", ready, 1);

    issue(enc_jal(21'd16), 32'h500, 32'd0, 32'd0);
    chk("pre_reset_jen", jen, 1);
    #3 rst_n = 1'b0;
    #1;
    chk("async_reset_valid", res_valid, 0);
    chk("async_reset_jen", jen, 0);
    chk("async_reset_ready", ready, 1);
    @(posedge clk); #1 rst_n = 1'b1;

`ifdef BRANCH_STATS_EN
    for (int k = 0; k < 3; k++) begin
      issue(enc_b(3'd0, 13'd8), 32'h100, 32'd9, 32'd9);
      ack_now();
    end
    for (int k = 0; k < 2; k++)
      issue(enc_b(3'd0, 13'd8), 32'h100, 32'd9, 32'd8);
    issue(enc_b(3'd3, 13'd8), 32'h100, 32'd9, 32'd9);
    step(1);
    chk("stats_taken", taken_cnt, 3);
    chk("stats_not_taken", not_taken_cnt, 2);
    chk("stats_jump", mf_cnt, 0);
`endif

    step(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
